// File: rtl/elevator_pkg.sv
// Shared elevator definitions: default geometry and the motion-state encoding
// used by both the request tracker and the car controller.
package elevator_pkg;

   localparam int DEFAULT_NUM_FLOORS          = 10;
   localparam int DEFAULT_FLOOR_WIDTH         = 4;
   localparam int DEFAULT_FLOOR_TRAVEL_CYCLES = 100;

   localparam logic [1:0] MOTION_IDLE = 2'b00;
   localparam logic [1:0] MOTION_UP   = 2'b01;
   localparam logic [1:0] MOTION_DOWN = 2'b10;

   // Both motor commands at once is not a direction; the car stays put.
   function automatic logic [1:0] decode_motion(input logic up, input logic down);
      case ({up, down})
         2'b10:   return MOTION_UP;
         2'b01:   return MOTION_DOWN;
         default: return MOTION_IDLE;
      endcase
   endfunction

endpackage

// File: rtl/floor_position_tracker.sv
// Car position: travel counter between floors plus the registered floor index,
// with a sticky fault for illegal motor commands.
module floor_position_tracker
   import elevator_pkg::*;
#(
   parameter int NUM_FLOORS          = DEFAULT_NUM_FLOORS,
   parameter int FLOOR_WIDTH         = DEFAULT_FLOOR_WIDTH,
   parameter int FLOOR_TRAVEL_CYCLES = DEFAULT_FLOOR_TRAVEL_CYCLES
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   moving_up,
   input  logic                   moving_down,
   output logic [FLOOR_WIDTH-1:0] current_floor,
   output logic                   at_floor,
   output logic                   motion_fault
);

   localparam int CNT_W = (FLOOR_TRAVEL_CYCLES > 1) ? $clog2(FLOOR_TRAVEL_CYCLES) : 1;
   localparam logic [CNT_W-1:0]       CNT_LAST  = CNT_W'(FLOOR_TRAVEL_CYCLES - 1);
   localparam logic [FLOOR_WIDTH-1:0] TOP_FLOOR = FLOOR_WIDTH'(NUM_FLOORS - 1);

   logic [CNT_W-1:0] travel_cnt;
   logic [1:0]       motion;
   logic [1:0]       last_dir;
   logic             blocked;
   logic             illegal;
   logic             reversal;

   always_comb begin
      motion   = decode_motion(moving_up, moving_down);
      blocked  = ((motion == MOTION_UP) && (current_floor == TOP_FLOOR)) ||
                 ((motion == MOTION_DOWN) && (current_floor == '0));
      illegal  = blocked || (moving_up && moving_down);
      // last_dir remembers the direction that built up a partial count, even across idle.
      reversal = (motion != MOTION_IDLE) && (travel_cnt != '0) && (motion != last_dir);
      at_floor = (travel_cnt == '0);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         current_floor <= '0;
         travel_cnt    <= '0;
         last_dir      <= MOTION_IDLE;
         motion_fault  <= 1'b0;
      end else begin
         if (illegal) begin
            motion_fault <= 1'b1;
         end
         if ((motion != MOTION_IDLE) && !blocked) begin
            last_dir <= motion;
            if (reversal) begin
               travel_cnt <= '0;
            end else if (travel_cnt == CNT_LAST) begin
               travel_cnt <= '0;
               if (motion == MOTION_UP) begin
                  current_floor <= current_floor + 1'b1;
               end else begin
                  current_floor <= current_floor - 1'b1;
               end
            end else begin
               travel_cnt <= travel_cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/request_tracker.sv
// Pending floor-call register with above/below scan and request count,
// alongside the car position tracker.
module request_tracker
   import elevator_pkg::*;
#(
   parameter int NUM_FLOORS          = DEFAULT_NUM_FLOORS,
   parameter int FLOOR_WIDTH         = DEFAULT_FLOOR_WIDTH,
   parameter int FLOOR_TRAVEL_CYCLES = DEFAULT_FLOOR_TRAVEL_CYCLES
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic [NUM_FLOORS-1:0]  button_req,
   input  logic                   clear_current_request,
   input  logic                   moving_up,
   input  logic                   moving_down,
   output logic [FLOOR_WIDTH-1:0] current_floor,
   output logic [NUM_FLOORS-1:0]  floor_requests,
   output logic                   has_request_above,
   output logic                   has_request_below,
   output logic                   at_floor,
   output logic [FLOOR_WIDTH-1:0] request_count,
   output logic                   motion_fault
);

   logic [NUM_FLOORS-1:0] clear_mask;

   floor_position_tracker #(
      .NUM_FLOORS          (NUM_FLOORS),
      .FLOOR_WIDTH         (FLOOR_WIDTH),
      .FLOOR_TRAVEL_CYCLES (FLOOR_TRAVEL_CYCLES)
   ) u_position (
      .clk           (clk),
      .reset_n       (reset_n),
      .moving_up     (moving_up),
      .moving_down   (moving_down),
      .current_floor (current_floor),
      .at_floor      (at_floor),
      .motion_fault  (motion_fault)
   );

   // The current floor's own bit is deliberately excluded from both above and below.
   always_comb begin
      clear_mask        = '0;
      has_request_above = 1'b0;
      has_request_below = 1'b0;
      request_count     = '0;
      for (int i = 0; i < NUM_FLOORS; i++) begin
         if (clear_current_request && (current_floor == FLOOR_WIDTH'(i))) begin
            clear_mask[i] = 1'b1;
         end
         if (floor_requests[i]) begin
            if (FLOOR_WIDTH'(i) > current_floor) begin
               has_request_above = 1'b1;
            end
            if (FLOOR_WIDTH'(i) < current_floor) begin
               has_request_below = 1'b1;
            end
            request_count = request_count + 1'b1;
         end
      end
   end

   // Clear is applied after the OR so a simultaneous press at the current floor loses.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         floor_requests <= '0;
      end else begin
         floor_requests <= (floor_requests | button_req) & ~clear_mask;
      end
   end

endmodule
